cam_fb_writer: RTL



---
 rtl/cam_fb_pkg.sv | 18 +
 rtl/cam_fb_writer_if.sv | 28 ++
 rtl/cam_fb_fifo.sv | 49 ++++
 rtl/cam_fb_writer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cam_fb_pkg.sv
// Shared encodings for the camera-to-framebuffer write bridge: capture modes,
// write-FSM state codes and the FIFO entry width helper.
package cam_fb_pkg;

    localparam logic [1:0] MODE_FULL = 2'd0;
    localparam logic [1:0] MODE_CROP = 2'd1;
    localparam logic [1:0] MODE_DEC2 = 2'd2;
    localparam logic [1:0] MODE_OFF  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CALL = 2'd2;

    function automatic int entry_w(input int addr_w, input int pix_w);
        return addr_w + pix_w;
    endfunction

endpackage

// File: rtl/cam_fb_writer_if.sv
// Pixel stream from the capture block and the call/done write port of the
// graphic module.
interface cam_fb_pix_if #(
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int PIX_W = 16
);
    logic             valid;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [PIX_W-1:0] data;

    modport master (output valid, x, y, data);
    modport slave  (input  valid, x, y, data);
endinterface

interface cam_fb_mem_if #(
    parameter int ADDR_W = 24,
    parameter int PIX_W  = 16
);
    logic              call;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;

    modport master (output call, addr, data, input  done);
    modport slave  (input  call, addr, data, output done);
endinterface

// File: rtl/cam_fb_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered read data.
// A write while full is accepted only when a read happens on the same edge.
module cam_fb_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] ram [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr)
            ram[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= ram[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/cam_fb_writer.sv
// Camera-to-framebuffer write bridge: crop/decimate filter, FIFO and the
// call/done write sequencer toward the graphic module.
//
//   state   | meaning
//   IDLE    | waiting for a queued pixel; pops the FIFO head when one exists
//   LOAD    | FIFO read data is valid; latch it onto mem addr/data
//   CALL    | write request held high until mem done
module cam_fb_writer
    import cam_fb_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int PIX_W    = 16,
    parameter int COL_BITS = 9,
    parameter int ADDR_W   = 24,
    parameter int DEPTH    = 16
) (
    input  logic            clk,
    input  logic            rst,
    cam_fb_pix_if.slave     pix,
    cam_fb_mem_if.master    mem,
    input  logic [1:0]      mode,
    input  logic [X_W-1:0]  win_x0,
    input  logic [Y_W-1:0]  win_y0,
    input  logic [X_W-1:0]  win_w,
    input  logic [Y_W-1:0]  win_h,
    output logic [15:0]     drop_cnt,
    output logic            busy
);
    localparam int EW = entry_w(ADDR_W, PIX_W);
    localparam logic [ADDR_W-1:0] COL_MASK = ADDR_W'((64'd1 << COL_BITS) - 64'd1);

    logic [X_W:0]        x_lo, x_hi;
    logic [Y_W:0]        y_lo, y_hi;
    logic [X_W-1:0]      x0, rx, rx_s;
    logic [Y_W-1:0]      y0, ry, ry_s;
    logic                crop_mode, dec_mode, in_win, pass;
    logic [ADDR_W-1:0]   addr_c;

    logic                f_valid;
    logic [EW-1:0]       f_entry;

    logic [EW-1:0]       fifo_rd_data;
    logic                fifo_full, fifo_empty;
    logic                pop;
    logic [1:0]          state;

    // Window bounds are compared one bit wider so x0+w never wraps.
    always_comb begin
        crop_mode = (mode == MODE_CROP) || (mode == MODE_DEC2);
        dec_mode  = (mode == MODE_DEC2);
        x_lo      = {1'b0, win_x0};
        x_hi      = x_lo + {1'b0, win_w};
        y_lo      = {1'b0, win_y0};
        y_hi      = y_lo + {1'b0, win_h};
        in_win    = ({1'b0, pix.x} >= x_lo) && ({1'b0, pix.x} < x_hi) &&
                    ({1'b0, pix.y} >= y_lo) && ({1'b0, pix.y} < y_hi);
        x0        = crop_mode ? win_x0 : '0;
        y0        = crop_mode ? win_y0 : '0;
        rx        = pix.x - x0;
        ry        = pix.y - y0;
        rx_s      = dec_mode ? (rx >> 1) : rx;
        ry_s      = dec_mode ? (ry >> 1) : ry;
        addr_c    = (ADDR_W'(ry_s) << COL_BITS) | (ADDR_W'(rx_s) & COL_MASK);
        case (mode)
            MODE_FULL: pass = 1'b1;
            MODE_CROP: pass = in_win;
            MODE_DEC2: pass = in_win && !rx[0] && !ry[0];
            default:   pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_valid <= 1'b0;
            f_entry <= '0;
        end else begin
            f_valid <= pix.valid && pass;
            if (pix.valid && pass)
                f_entry <= {addr_c, pix.data};
        end
    end

    assign pop = (state == ST_IDLE) && !fifo_empty;

    cam_fb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (f_valid),
        .wr_data (f_entry),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A pop on the same edge frees a slot, so only an unmatched full push drops.
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (f_valid && fifo_full && !pop && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem.call <= 1'b0;
            mem.addr <= '0;
            mem.data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    mem.addr <= fifo_rd_data[EW-1 -: ADDR_W];
                    mem.data <= fifo_rd_data[PIX_W-1:0];
                    mem.call <= 1'b1;
                    state    <= ST_CALL;
                end
                ST_CALL: begin
                    if (mem.done) begin
                        mem.call <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    mem.call <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = !fifo_empty || (state != ST_IDLE);

endmodule
